// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: state encoding,
// opcode/funct values, ALU control codes and datapath select encodings.
package mips_ctrl_pkg;

  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned ALU_CTRL_W = 3;
  localparam int unsigned SRCB_W     = 2;
  localparam int unsigned RDST_W     = 2;
  localparam int unsigned WB_W       = 3;
  localparam int unsigned PCSRC_W    = 3;

  // Exception entry address; the datapath ties pc mux input 4 to it.
  localparam logic [31:0] TRAP_VECTOR = 32'h0000_00FC;

  // addi shares the address-calculation state with lw/sw (identical controls),
  // which keeps the state space within 4 bits.
  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_R_EXEC   = 4'd3,
    S_R_WB     = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_LOAD_WB  = 4'd7,
    S_MEM_WR   = 4'd8,
    S_ADDI_WB  = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13,
    S_LUI      = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FN_JR  = 6'h08;
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'd7;

  localparam logic [SRCB_W-1:0] SRCB_REGB    = 2'd0;
  localparam logic [SRCB_W-1:0] SRCB_FOUR    = 2'd1;
  localparam logic [SRCB_W-1:0] SRCB_IMM     = 2'd2;
  localparam logic [SRCB_W-1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [RDST_W-1:0] RDST_RT = 2'd0;
  localparam logic [RDST_W-1:0] RDST_RD = 2'd1;
  localparam logic [RDST_W-1:0] RDST_RA = 2'd2;

  localparam logic [WB_W-1:0] WB_ALUOUT = 3'd0;
  localparam logic [WB_W-1:0] WB_MDR    = 3'd1;
  localparam logic [WB_W-1:0] WB_PC     = 3'd2;
  localparam logic [WB_W-1:0] WB_LUI    = 3'd3;

  localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 3'd0;
  localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 3'd1;
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 3'd2;
  localparam logic [PCSRC_W-1:0] PCSRC_REGA   = 3'd3;
  localparam logic [PCSRC_W-1:0] PCSRC_TRAP   = 3'd4;

endpackage

// File: rtl/alu_ctrl_decode.sv
// R-type funct to ALU control decode.
//   funct      : IR[5:0]
//   alu_ctrl_c : ALU operation code (ADD when funct is not recognised)
//   valid_c    : funct is a supported R-type ALU operation
module alu_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [FUNCT_W-1:0]    funct,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_c,
  output logic                  valid_c
);

  always_comb begin
    alu_ctrl_c = ALU_ADD;
    valid_c    = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl_c = ALU_ADD;
      FN_SUB:  alu_ctrl_c = ALU_SUB;
      FN_AND:  alu_ctrl_c = ALU_AND;
      FN_OR:   alu_ctrl_c = ALU_OR;
      FN_SLT:  alu_ctrl_c = ALU_SLT;
      default: valid_c    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath. Outputs decode from the
// current state; pc_write in BRANCH additionally uses the ALU zero flag.
//   clk, reset        : clock, synchronous active-high reset
//   opcode, funct     : instruction fields, stable from DECODE onward
//   zero              : ALU zero flag for the current cycle
//   pc_write..epc_write : write enables / memory strobes
//   alu_src_a..pc_source : datapath mux selects
//   illegal_op        : pulses in the TRAP cycle
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0]    funct,
  input  logic                  zero,
  output logic                  pc_write,
  output logic                  i_or_d,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic                  epc_write,
  output logic                  alu_src_a,
  output logic [SRCB_W-1:0]     alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [RDST_W-1:0]     reg_dst,
  output logic [WB_W-1:0]       mem_to_reg,
  output logic [PCSRC_W-1:0]    pc_source,
  output logic                  illegal_op
);

  state_t                  state_q, state_d;
  logic [ALU_CTRL_W-1:0]   fn_alu_ctrl;
  logic                    fn_valid;

  alu_ctrl_decode u_alu_ctrl_decode (
    .funct      (funct),
    .alu_ctrl_c (fn_alu_ctrl),
    .valid_c    (fn_valid)
  );

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = S_RESET;
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    epc_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    alu_ctrl   = ALU_AND;
    reg_dst    = RDST_RT;
    mem_to_reg = WB_ALUOUT;
    pc_source  = PCSRC_ALU;
    illegal_op = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_ctrl  = ALU_ADD;
        pc_write  = 1'b1;
        state_d   = S_DECODE;
      end

      // Branch target is computed speculatively into ALUOut here.
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        alu_ctrl  = ALU_ADD;
        case (opcode)
          OP_RTYPE:             state_d = (funct == FN_JR) ? S_JR : S_R_EXEC;
          OP_LW, OP_SW, OP_ADDI: state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:       state_d = S_BRANCH;
          OP_J:                 state_d = S_JUMP;
          OP_JAL:               state_d = S_JAL;
          OP_LUI:               state_d = S_LUI;
          default:              state_d = S_TRAP;
        endcase
      end

      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = fn_alu_ctrl;
        state_d   = fn_valid ? S_R_WB : S_TRAP;
      end

      S_R_WB: begin
        reg_dst   = RDST_RD;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = ALU_ADD;
        case (opcode)
          OP_LW:   state_d = S_MEM_RD;
          OP_SW:   state_d = S_MEM_WR;
          OP_ADDI: state_d = S_ADDI_WB;
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM_RD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        state_d  = S_LOAD_WB;
      end

      S_LOAD_WB: begin
        mem_to_reg = WB_MDR;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        state_d   = S_FETCH;
      end

      S_ADDI_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      // Only Mealy term: taken/not-taken folds into pc_write.
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_write  = (opcode == OP_BNE) ? ~zero : zero;
        state_d   = S_FETCH;
      end

      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end

      // PC already holds the return address (PC+4) from FETCH.
      S_JAL: begin
        reg_dst    = RDST_RA;
        mem_to_reg = WB_PC;
        reg_write  = 1'b1;
        pc_source  = PCSRC_JUMP;
        pc_write   = 1'b1;
        state_d    = S_FETCH;
      end

      S_JR: begin
        pc_source = PCSRC_REGA;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end

      S_LUI: begin
        mem_to_reg = WB_LUI;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end

      S_TRAP: begin
        epc_write  = 1'b1;
        illegal_op = 1'b1;
        pc_source  = PCSRC_TRAP;
        pc_write   = 1'b1;
        state_d    = S_FETCH;
      end

      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style control FSM for the multicycle MIPS datapath.
- Decodes opcode/funct and drives the datapath's write enables and mux selects (ALU operand A/B, PC source, register destination, write-back source) every cycle.
- Sits directly upstream of the datapath selector muxes; its select outputs connect straight to their sel inputs.
- One instruction in flight; no pipelining.

Parameters:
- TRAP_VECTOR, 32'h0000_00FC, PC loaded on illegal opcode (exported via pc_source=4; datapath ties mux in4 to it).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag (combinational, current cycle).
- pc_write  out  1  PC register load enable (includes branch decision).
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- reg_write  out  1  register file write enable.
- epc_write  out  1  EPC load (trap only).
- alu_src_a  out  1  0=PC, 1=regA.
- alu_src_b  out  2  0=regB, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
- alu_ctrl  out  3  0=AND, 1=OR, 2=ADD, 6=SUB, 7=SLT.
- reg_dst  out  2  0=rt, 1=rd, 2=5'd31; 3 is reserved and never driven.
- mem_to_reg  out  3  0=ALUOut, 1=MDR, 2=PC, 3=imm<<16; 4–7 reserved.
- pc_source  out  3  0=ALU result, 1=ALUOut, 2=jump target, 3=regA, 4=TRAP_VECTOR.
- illegal_op  out  1  one-cycle pulse in TRAP.

Behaviour:
- State register resets synchronously to S_RESET. In S_RESET, every enable is 0 and every select is 0. S_RESET always goes to FETCH on the next edge.
- Outputs are decoded combinationally from state. The one exception is pc_write in BRANCH, which also depends on zero (Mealy term).
- FETCH:
  - i_or_d=0, mem_read=1, ir_write=1, alu_src_a=0, alu_src_b=1, alu_ctrl=ADD, pc_source=0, pc_write=1.
  - Next state: DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=3, alu_ctrl=ADD (branch target into ALUOut).
  - Dispatch on opcode:
    - 0x00 R-type → R_EXEC, except funct 0x08 → JR.
    - 0x23 lw, 0x2B sw, 0x08 addi → MEM_ADDR / ADDI_EXEC.
    - 0x04 beq, 0x05 bne → BRANCH.
    - 0x02 → JUMP; 0x03 → JAL; 0x0F → LUI.
    - Anything else → TRAP.
- R_EXEC:
  - alu_src_a=1, alu_src_b=0; alu_ctrl from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
  - Unknown funct → TRAP.
  - Next state: R_WB.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write=1. Next: FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD. Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD: i_or_d=1, mem_read=1. Next: LOAD_WB.
- LOAD_WB: reg_dst=0, mem_to_reg=1, reg_write=1. Next: FETCH.
- MEM_WR: i_or_d=1, mem_write=1. Next: FETCH.
- ADDI_EXEC: as MEM_ADDR. Next: ADDI_WB (reg_dst=0, mem_to_reg=0, reg_write=1), then FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=0, SUB, pc_source=1.
  - pc_write = zero for beq, !zero for bne.
  - Next: FETCH.
- JUMP: pc_source=2, pc_write=1. Next: FETCH.
- JAL:
  - reg_dst=2, mem_to_reg=2, reg_write=1, pc_source=2, pc_write=1. Next: FETCH.
  - The value written is PC, which already holds PC+4.
- JR: pc_source=3, pc_write=1. Next: FETCH.
- LUI: reg_dst=0, mem_to_reg=3, reg_write=1. Next: FETCH.
- TRAP: epc_write=1, illegal_op=1, pc_source=4, pc_write=1. Next: FETCH.
- Invariants:
  - Never more than one of mem_read/mem_write high.
  - reg_write and mem_write are never high together.
- Reset asserted in any state: on the next edge the state becomes S_RESET. Write enables and strobes are 0 in the cycle after the edge, regardless of the aborted instruction.
- Unreachable state encodings → S_RESET next cycle.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum (typedef state_t, 4-bit);
  - opcode/funct localparams;
  - alu_ctrl codes;
  - select encodings for alu_src_b, reg_dst, mem_to_reg, pc_source.
- One sub-module, alu_ctrl_decode (combinational funct→alu_ctrl plus a valid flag), reused by R_EXEC and the TRAP decision.

Test Plan:
- Reset 2 cycles, release → cycle 1 S_RESET (all outputs 0); cycle 2 FETCH with mem_read=1, ir_write=1, pc_write=1, alu_src_b=1.
- opcode 0x00, funct 0x22 (sub) → FETCH, DECODE, R_EXEC (alu_ctrl=6), R_WB (reg_dst=1, reg_write=1), back to FETCH; 4 cycles total.
- opcode 0x23 (lw) → 5 cycles. MEM_RD has i_or_d=1, mem_read=1. LOAD_WB has mem_to_reg=1, reg_dst=0. sw (0x2B) → 4 cycles, mem_write=1 only in MEM_WR.
- beq with zero=1 → pc_write=1, pc_source=1 in BRANCH. bne with zero=1 → pc_write=0. Both return to FETCH after 3 cycles.
- jal (0x03) → reg_dst=2, mem_to_reg=2, reg_write=1, pc_source=2, pc_write=1 in one cycle. opcode 0x3F → TRAP with epc_write=1, illegal_op=1, pc_source=4.
- Reset asserted during MEM_WR → next cycle S_RESET, mem_write=0; FETCH follows once reset deasserts.
